// File: rtl/vga_image_window_ctrl_if.sv
// Display-path bundle between VGA driver/host/ROM and the image window controller.
// master = surrounding system (drives positions, config, ROM data); slave = controller.
interface vga_image_window_ctrl_if #(
  parameter int ADDR_W = 14
) ();
  logic [9:0]        pixel_xpos;
  logic [9:0]        pixel_ypos;
  logic              move_en;
  logic              cfg_valid;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic              cfg_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [29:0]       pixel_data;
  logic [9:0]        win_x;
  logic [9:0]        win_y;

  modport master (
    output pixel_xpos, pixel_ypos, move_en, cfg_valid, cfg_x, cfg_y, rom_data,
    input  cfg_ready, rom_addr, pixel_data, win_x, win_y
  );

  modport slave (
    input  pixel_xpos, pixel_ypos, move_en, cfg_valid, cfg_x, cfg_y, rom_data,
    output cfg_ready, rom_addr, pixel_data, win_x, win_y
  );
endinterface

// File: rtl/vga_image_window_ctrl.sv
// Places an IMG_W x IMG_H RGB565 image on the VGA screen: ROM addressing, valid alignment,
// RGB565->30-bit expansion, and frame-synchronous origin moves (host request or bounce).
module vga_image_window_ctrl #(
  parameter int H_DISP  = 640,
  parameter int V_DISP  = 480,
  parameter int IMG_W   = 240,
  parameter int IMG_H   = 40,
  parameter int ADDR_W  = 14,
  parameter int ROM_LAT = 1,
  parameter int STEP    = 2,
  parameter int INIT_X  = 100,
  parameter int INIT_Y  = 50
) (
  input logic                   driver_clk,
  input logic                   sys_rst,
  vga_image_window_ctrl_if.slave bus
);
  localparam logic [9:0]         X_MAX   = 10'(H_DISP - IMG_W);
  localparam logic [9:0]         Y_MAX   = 10'(V_DISP - IMG_H);
  localparam logic signed [10:0] X_MAX_S = 11'(H_DISP - IMG_W);
  localparam logic signed [10:0] Y_MAX_S = 11'(V_DISP - IMG_H);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state_q;
  logic [9:0]        win_x_q, win_y_q, pend_x_q, pend_y_q;
  logic              dir_x_q, dir_y_q; // 1 = moving towards 0
  logic              cfg_ready_q;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  vld_q, vld_d;
  logic [29:0]       pix_q, pix_d;
  logic              at_end_q, at_end_d;

  logic              in_win, frame_end;
  logic [9:0]        dx, dy, cx, cy, bx_win, by_win;
  logic signed [10:0] bx, by;
  logic              bx_flip, by_flip;
  logic [4:0]        r5, b5;
  logic [5:0]        g6;
  logic [1:0]        unused_g_lsb;

  assign unused_g_lsb = bus.rom_data[6:5];

  always_comb begin
    in_win = ({1'b0, bus.pixel_xpos} >= {1'b0, win_x_q})
          && ({1'b0, bus.pixel_xpos} <  {1'b0, win_x_q} + 11'(IMG_W))
          && ({1'b0, bus.pixel_ypos} >= {1'b0, win_y_q})
          && ({1'b0, bus.pixel_ypos} <  {1'b0, win_y_q} + 11'(IMG_H))
          && (bus.pixel_xpos < 10'(H_DISP))
          && (bus.pixel_ypos < 10'(V_DISP));
    dx = bus.pixel_xpos - win_x_q;
    dy = bus.pixel_ypos - win_y_q;
    rom_addr_d = in_win ? ADDR_W'(dy) * ADDR_W'(IMG_W) + ADDR_W'(dx) : rom_addr_q;
    vld_d = {vld_q[ROM_LAT-1:0], in_win};

    r5 = bus.rom_data[15:11];
    g6 = bus.rom_data[10:5];
    b5 = bus.rom_data[4:0];
    // Replicate MSBs into the low bits so full-scale 565 maps to full-scale 10-bit.
    pix_d = vld_q[ROM_LAT] ? {r5, r5, g6, g6[5:2], b5, b5} : 30'd0;

    at_end_d  = (bus.pixel_xpos == 10'(H_DISP - 1)) && (bus.pixel_ypos == 10'(V_DISP - 1));
    frame_end = at_end_d && !at_end_q;

    cx = (bus.cfg_x > X_MAX) ? X_MAX : bus.cfg_x;
    cy = (bus.cfg_y > Y_MAX) ? Y_MAX : bus.cfg_y;

    // Reaching an edge exactly also turns around, so the next step heads back inward.
    bx = dir_x_q ? $signed({1'b0, win_x_q}) - STEP_S : $signed({1'b0, win_x_q}) + STEP_S;
    by = dir_y_q ? $signed({1'b0, win_y_q}) - STEP_S : $signed({1'b0, win_y_q}) + STEP_S;
    bx_win = bx[9:0];
    bx_flip = 1'b0;
    if (bx >= X_MAX_S) begin
      bx_win = X_MAX;
      bx_flip = 1'b1;
    end else if (bx <= 11'sd0) begin
      bx_win = 10'd0;
      bx_flip = 1'b1;
    end
    by_win = by[9:0];
    by_flip = 1'b0;
    if (by >= Y_MAX_S) begin
      by_win = Y_MAX;
      by_flip = 1'b1;
    end else if (by <= 11'sd0) begin
      by_win = 10'd0;
      by_flip = 1'b1;
    end
  end

  always_ff @(posedge driver_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rom_addr_q <= '0;
      vld_q      <= '0;
      pix_q      <= '0;
      at_end_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      vld_q      <= vld_d;
      pix_q      <= pix_d;
      at_end_q   <= at_end_d;
    end
  end

  always_ff @(posedge driver_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
      win_x_q     <= 10'(INIT_X);
      win_y_q     <= 10'(INIT_Y);
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_end && bus.move_en) begin
            win_x_q <= bx_win;
            win_y_q <= by_win;
            dir_x_q <= dir_x_q ^ bx_flip;
            dir_y_q <= dir_y_q ^ by_flip;
          end
          // A request landing on frame_end waits for the next frame; bounce still runs above.
          if (bus.cfg_valid && cfg_ready_q) begin
            pend_x_q    <= cx;
            pend_y_q    <= cy;
            state_q     <= PEND;
            cfg_ready_q <= 1'b0;
          end
        end
        PEND: begin
          if (frame_end) begin
            win_x_q     <= pend_x_q;
            win_y_q     <= pend_y_q;
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pixel_data = pix_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.cfg_ready  = cfg_ready_q;
endmodule

// File: tb/tb_vga_image_window_ctrl.sv
// Directed bench for vga_image_window_ctrl with a 1-cycle ROM model (F800 at 9599, else 1234).
module tb_vga_image_window_ctrl;
  logic driver_clk = 1'b0;
  logic sys_rst    = 1'b1;
  int   tests = 0;
  int   fails = 0;

  vga_image_window_ctrl_if #(.ADDR_W(14)) bus ();

  vga_image_window_ctrl dut (
    .driver_clk (driver_clk),
    .sys_rst    (sys_rst),
    .bus        (bus)
  );

  always #5 driver_clk = ~driver_clk;

  always @(posedge driver_clk)
    bus.rom_data <= (bus.rom_addr == 14'd9599) ? 16'hF800 : 16'h1234;

  task automatic tick();
    @(posedge driver_clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    bus.pixel_xpos = 10'(x);
    bus.pixel_ypos = 10'(y);
  endtask

  task automatic frame_end_pulse();
    set_pos(639, 479);
    tick();
    set_pos(0, 0);
    tick();
  endtask

  task automatic test_reset();
    set_pos(0, 0);
    bus.move_en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_x = '0;
    bus.cfg_y = '0;
    sys_rst = 1'b1;
    tick();
    tick();
    tests++; if (bus.rom_addr !== 14'd0) begin fails++; $display("FAIL reset_rom_addr got %0d exp 0", bus.rom_addr); end
    tests++; if (bus.pixel_data !== 30'd0) begin fails++; $display("FAIL reset_pixel got %h exp 0", bus.pixel_data); end
    tests++; if (bus.win_x !== 10'd100 || bus.win_y !== 10'd50) begin fails++; $display("FAIL reset_win got (%0d,%0d) exp (100,50)", bus.win_x, bus.win_y); end
    tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got %b exp 1", bus.cfg_ready); end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_pixel_path();
    set_pos(100, 50);
    tick();
    tests++; if (bus.rom_addr !== 14'd0) begin fails++; $display("FAIL origin_addr got %0d exp 0", bus.rom_addr); end
    set_pos(99, 50);
    tick();
    tests++; if (bus.pixel_data !== 30'd0) begin fails++; $display("FAIL pixel_early got %h exp 0", bus.pixel_data); end
    tick();
    tests++; if (bus.pixel_data !== 30'h04245294) begin fails++; $display("FAIL origin_pixel got %h exp 04245294", bus.pixel_data); end
    tick();
    tests++; if (bus.pixel_data !== 30'd0) begin fails++; $display("FAIL left_of_win_pixel got %h exp 0", bus.pixel_data); end
    tests++; if (bus.rom_addr !== 14'd0) begin fails++; $display("FAIL addr_hold got %0d exp 0", bus.rom_addr); end
  endtask

  task automatic test_window_edge();
    set_pos(339, 89);
    tick();
    tests++; if (bus.rom_addr !== 14'd9599) begin fails++; $display("FAIL corner_addr got %0d exp 9599", bus.rom_addr); end
    set_pos(340, 89);
    tick();
    tick();
    tests++; if (bus.pixel_data !== 30'h3FF00000) begin fails++; $display("FAIL red_pixel got %h exp 3FF00000", bus.pixel_data); end
    tick();
    tests++; if (bus.pixel_data !== 30'd0) begin fails++; $display("FAIL right_of_win_pixel got %h exp 0", bus.pixel_data); end
    tests++; if (bus.rom_addr !== 14'd9599) begin fails++; $display("FAIL corner_addr_hold got %0d exp 9599", bus.rom_addr); end
    set_pos(0, 0);
    tick();
  endtask

  task automatic test_cfg_clamp();
    bus.cfg_valid = 1'b1;
    bus.cfg_x = 10'd600;
    bus.cfg_y = 10'd470;
    tick();
    tests++; if (bus.cfg_ready !== 1'b0) begin fails++; $display("FAIL pend_ready got %b exp 0", bus.cfg_ready); end
    bus.cfg_x = 10'd5;
    bus.cfg_y = 10'd7;
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    tests++; if (bus.win_x !== 10'd100 || bus.win_y !== 10'd50) begin fails++; $display("FAIL pend_win got (%0d,%0d) exp (100,50)", bus.win_x, bus.win_y); end
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd400 || bus.win_y !== 10'd440) begin fails++; $display("FAIL clamp_win got (%0d,%0d) exp (400,440)", bus.win_x, bus.win_y); end
    tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL apply_ready got %b exp 1", bus.cfg_ready); end
  endtask

  task automatic test_bounce();
    bus.cfg_valid = 1'b1;
    bus.cfg_x = 10'd398;
    bus.cfg_y = 10'd100;
    tick();
    bus.cfg_valid = 1'b0;
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd398 || bus.win_y !== 10'd100) begin fails++; $display("FAIL bounce_start got (%0d,%0d) exp (398,100)", bus.win_x, bus.win_y); end
    bus.move_en = 1'b1;
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd400 || bus.win_y !== 10'd102) begin fails++; $display("FAIL bounce_1 got (%0d,%0d) exp (400,102)", bus.win_x, bus.win_y); end
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd398 || bus.win_y !== 10'd104) begin fails++; $display("FAIL bounce_2 got (%0d,%0d) exp (398,104)", bus.win_x, bus.win_y); end
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd396 || bus.win_y !== 10'd106) begin fails++; $display("FAIL bounce_3 got (%0d,%0d) exp (396,106)", bus.win_x, bus.win_y); end
  endtask

  task automatic test_back_to_back();
    // Request accepted on the frame_end cycle: bounce this frame, apply next frame.
    bus.cfg_valid = 1'b1;
    bus.cfg_x = 10'd10;
    bus.cfg_y = 10'd20;
    set_pos(639, 479);
    tick();
    bus.cfg_valid = 1'b0;
    set_pos(0, 0);
    tick();
    tests++; if (bus.win_x !== 10'd394 || bus.win_y !== 10'd108) begin fails++; $display("FAIL accept_bounce got (%0d,%0d) exp (394,108)", bus.win_x, bus.win_y); end
    tests++; if (bus.cfg_ready !== 1'b0) begin fails++; $display("FAIL accept_ready got %b exp 0", bus.cfg_ready); end
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd10 || bus.win_y !== 10'd20) begin fails++; $display("FAIL pend_beats_bounce got (%0d,%0d) exp (10,20)", bus.win_x, bus.win_y); end
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd8 || bus.win_y !== 10'd22) begin fails++; $display("FAIL dir_kept got (%0d,%0d) exp (8,22)", bus.win_x, bus.win_y); end
  endtask

  task automatic test_held_end();
    set_pos(639, 479);
    tick();
    tick();
    tick();
    set_pos(0, 0);
    tick();
    tests++; if (bus.win_x !== 10'd6 || bus.win_y !== 10'd24) begin fails++; $display("FAIL held_end got (%0d,%0d) exp (6,24)", bus.win_x, bus.win_y); end
    bus.move_en = 1'b0;
  endtask

  task automatic test_reset_pend();
    set_pos(6, 24);
    tick();
    tick();
    tick();
    tests++; if (bus.pixel_data !== 30'h04245294) begin fails++; $display("FAIL moved_origin_pixel got %h exp 04245294", bus.pixel_data); end
    bus.cfg_valid = 1'b1;
    bus.cfg_x = 10'd50;
    bus.cfg_y = 10'd60;
    tick();
    bus.cfg_valid = 1'b0;
    tests++; if (bus.cfg_ready !== 1'b0) begin fails++; $display("FAIL pre_rst_ready got %b exp 0", bus.cfg_ready); end
    sys_rst = 1'b1;
    #1;
    tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL async_rst_ready got %b exp 1", bus.cfg_ready); end
    tests++; if (bus.win_x !== 10'd100 || bus.win_y !== 10'd50) begin fails++; $display("FAIL async_rst_win got (%0d,%0d) exp (100,50)", bus.win_x, bus.win_y); end
    tests++; if (bus.pixel_data !== 30'd0) begin fails++; $display("FAIL async_rst_pixel got %h exp 0", bus.pixel_data); end
    tick();
    sys_rst = 1'b0;
    set_pos(0, 0);
    tick();
    frame_end_pulse();
    tests++; if (bus.win_x !== 10'd100 || bus.win_y !== 10'd50) begin fails++; $display("FAIL pend_discarded got (%0d,%0d) exp (100,50)", bus.win_x, bus.win_y); end
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_window_edge();
    test_cfg_clamp();
    test_bounce();
    test_back_to_back();
    test_held_end();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
